// File: rtl/vga_grid_renderer.sv
// 640x480@60Hz VGA scanner that paints a 16x16 occupancy grid, sampled once per frame
// at the start of vertical blanking so a frame never shows two different grids.
module vga_grid_renderer #(
    parameter int          CELL_PX      = 24,
    parameter int          X_OFF        = 128,
    parameter int          Y_OFF        = 48,
    parameter logic [11:0] FILL_COLOR   = 12'hF80,
    parameter logic [11:0] EMPTY_COLOR  = 12'h111,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF,
    parameter int          H_VISIBLE    = 640,
    parameter int          H_FRONT      = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BACK       = 48,
    parameter int          V_VISIBLE    = 480,
    parameter int          V_FRONT      = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BACK       = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] grid_in,
    output logic         hsync,
    output logic         vsync,
    output logic [11:0]  rgb,
    output logic         video_on,
    output logic         frame_tick
);

    localparam int PF_PX = 16 * CELL_PX;

    localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] PF_X0     = 10'(X_OFF);
    localparam logic [9:0] PF_X1     = 10'(X_OFF + PF_PX - 1);
    localparam logic [9:0] PF_Y0     = 10'(Y_OFF);
    localparam logic [9:0] PF_Y1     = 10'(Y_OFF + PF_PX - 1);
    localparam logic [9:0] X_LOAD    = 10'(X_OFF - 1);
    localparam logic [9:0] Y_LOAD    = 10'(Y_OFF - 1);
    localparam logic [9:0] RING_X1   = 10'(X_OFF + PF_PX);
    localparam logic [9:0] RING_Y1   = 10'(Y_OFF + PF_PX);
    localparam logic [4:0] SUB_LAST  = 5'(CELL_PX - 1);

    logic [1:0]   div;
    logic         pix_tick;
    logic [9:0]   h;
    logic [9:0]   v;
    logic [4:0]   sub_x;
    logic [4:0]   sub_y;
    logic [3:0]   col;
    logic [3:0]   row;
    logic [255:0] grid_q;

    logic         h_last;
    logic         in_x;
    logic         in_y;
    logic         ring_x;
    logic         ring_y;
    logic         visible;
    logic         snap;
    logic [11:0]  pix_rgb;

    assign pix_tick = (div == 2'd3);
    assign h_last   = (h == H_LAST);
    assign in_x     = (h >= PF_X0) && (h <= PF_X1);
    assign in_y     = (v >= PF_Y0) && (v <= PF_Y1);
    assign ring_x   = (h >= X_LOAD) && (h <= RING_X1);
    assign ring_y   = (v >= Y_LOAD) && (v <= RING_Y1);
    assign visible  = (h < H_VIS) && (v < V_VIS);
    assign snap     = pix_tick && (h == 10'd0) && (v == V_VIS);

    assign frame_tick = snap;

    // Colour of the pixel at the current (h,v); registered below so all outputs share one lag.
    always_comb begin
        pix_rgb = 12'h000;
        if (visible) begin
            if (in_x && in_y) begin
                pix_rgb = grid_q[{col, row}] ? FILL_COLOR : EMPTY_COLOR;
            end else if (ring_x && ring_y) begin
                pix_rgb = BORDER_COLOR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (pix_tick) begin
            if (h_last) begin
                h <= 10'd0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Cell position is tracked incrementally so no divider sits in the pixel path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_x <= 5'd0;
            col   <= 4'd0;
            sub_y <= 5'd0;
            row   <= 4'd0;
        end else if (pix_tick) begin
            if (h == X_LOAD) begin
                sub_x <= 5'd0;
                col   <= 4'd0;
            end else if (in_x) begin
                if (sub_x == SUB_LAST) begin
                    sub_x <= 5'd0;
                    col   <= col + 4'd1;
                end else begin
                    sub_x <= sub_x + 5'd1;
                end
            end
            if (h_last) begin
                if (v == Y_LOAD) begin
                    sub_y <= 5'd0;
                    row   <= 4'd0;
                end else if (in_y) begin
                    if (sub_y == SUB_LAST) begin
                        sub_y <= 5'd0;
                        row   <= row + 4'd1;
                    end else begin
                        sub_y <= sub_y + 5'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grid_q <= '0;
        end else if (snap) begin
            grid_q <= grid_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            rgb      <= 12'h000;
            video_on <= 1'b0;
        end else if (pix_tick) begin
            hsync    <= !((h >= HS_START) && (h < HS_END));
            vsync    <= !((v >= VS_START) && (v < VS_END));
            rgb      <= pix_rgb;
            video_on <= visible;
        end
    end

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Directed bench for vga_grid_renderer on a shrunken raster (56x45 pixels, 2-px cells)
// so several whole frames fit in a short run; expectations come from a division-based pixel model.
module tb_vga_grid_renderer;

  localparam int CELL = 2;
  localparam int XO   = 4;
  localparam int YO   = 3;
  localparam int HV   = 40;
  localparam int HF   = 4;
  localparam int HS   = 6;
  localparam int HB   = 6;
  localparam int VV   = 38;
  localparam int VF   = 2;
  localparam int VS   = 2;
  localparam int VB   = 3;
  localparam int HT   = HV + HF + HS + HB;
  localparam int VT   = VV + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * 4;

  localparam logic [11:0] FILL   = 12'hF80;
  localparam logic [11:0] EMPTY  = 12'h111;
  localparam logic [11:0] BORDER = 12'hFFF;

  logic         clk;
  logic         reset;
  logic [255:0] grid_in;
  logic         hsync;
  logic         vsync;
  logic [11:0]  rgb;
  logic         video_on;
  logic         frame_tick;

  vga_grid_renderer #(
    .CELL_PX(CELL), .X_OFF(XO), .Y_OFF(YO),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .grid_in(grid_in),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .video_on(video_on),
    .frame_tick(frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bookkeeping
  int checks = 0;
  int errors = 0;
  int pix_err = 0;
  int hold_err = 0;
  int tick_err = 0;
  int tick_q[$];

  int mh = 0;
  int mv = 0;
  logic [255:0] disp_grid;
  logic [11:0]  prev_rgb;
  logic         prev_hs;
  logic         prev_vs;
  logic         prev_von;

  logic [11:0] fb_rgb [0:VT-1][0:HT-1];
  logic        fb_hs  [0:VT-1][0:HT-1];
  logic        fb_vs  [0:VT-1][0:HT-1];
  logic        fb_von [0:VT-1][0:HT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [255:0] g);
    if (h >= HV || v >= VV) return 12'h000;
    if (h >= XO && h < XO + 16 * CELL && v >= YO && v < YO + 16 * CELL)
      return g[((h - XO) / CELL) * 16 + (v - YO) / CELL] ? FILL : EMPTY;
    if (h >= XO - 1 && h <= XO + 16 * CELL && v >= YO - 1 && v <= YO + 16 * CELL)
      return BORDER;
    return 12'h000;
  endfunction

  task automatic set_prev_reset();
    prev_rgb = 12'h000;
    prev_hs  = 1'b1;
    prev_vs  = 1'b1;
    prev_von = 1'b0;
  endtask

  // driver: one pixel period; the sample after the 4th edge shows pixel (mh,mv)
  task automatic step();
    logic exp_ft;
    logic exp_hs;
    logic exp_vs;
    logic exp_von;
    @(posedge clk); #1;
    if (frame_tick !== 1'b0) tick_err++;
    @(posedge clk); @(posedge clk); #1;
    exp_ft = (mh == 0 && mv == VV);
    if (frame_tick !== exp_ft) tick_err++;
    if (frame_tick === 1'b1) tick_q.push_back(cyc);
    if (rgb !== prev_rgb || hsync !== prev_hs || vsync !== prev_vs || video_on !== prev_von)
      hold_err++;
    @(posedge clk); #1;
    fb_rgb[mv][mh] = rgb;
    fb_hs[mv][mh]  = hsync;
    fb_vs[mv][mh]  = vsync;
    fb_von[mv][mh] = video_on;
    exp_hs  = !(mh >= HV + HF && mh < HV + HF + HS);
    exp_vs  = !(mv >= VV + VF && mv < VV + VF + VS);
    exp_von = (mh < HV && mv < VV);
    if (rgb !== exp_rgb(mh, mv, disp_grid) || hsync !== exp_hs || vsync !== exp_vs ||
        video_on !== exp_von)
      pix_err++;
    prev_rgb = rgb;
    prev_hs  = hsync;
    prev_vs  = vsync;
    prev_von = video_on;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  // runs from the current position to the end of the frame
  task automatic run_frame(input int chg_v, input logic [255:0] chg_val);
    bit first = 1'b1;
    while (first || !(mh == 0 && mv == 0)) begin
      first = 1'b0;
      if (mv == chg_v && mh == 0) grid_in = chg_val;
      step();
    end
  endtask

  logic [255:0] col0_pat;
  logic [255:0] one_bit;
  logic [255:0] top_bit;

  initial begin
    int cnt;
    int bad;
    int steps;

    one_bit  = 256'd1;
    top_bit  = one_bit << 255;
    col0_pat = 256'h0;
    col0_pat[15:0] = 16'hFFFF;

    // reset state
    reset   = 1'b1;
    grid_in = one_bit;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_rgb", rgb, 12'h000);
    check("rst_video_on", video_on, 1'b0);
    check("rst_frame_tick", frame_tick, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    set_prev_reset();
    mh = 0;
    mv = 0;

    // frame 0: empty snapshot; sync shape
    disp_grid = 256'h0;
    run_frame(-1, 256'h0);
    check("f0_pixels", pix_err, 0);
    cnt = 0;
    for (int x = 0; x < HT; x++) if (fb_hs[0][x] === 1'b0) cnt++;
    check("hsync_low_px_line0", cnt, HS);
    bad = 0;
    for (int y = 0; y < VT; y++) begin
      cnt = 0;
      for (int x = 0; x < HT; x++) if (fb_hs[y][x] === 1'b0) cnt++;
      if (cnt != HS) bad++;
    end
    check("hsync_bad_lines", bad, 0);
    cnt = 0;
    for (int y = 0; y < VT; y++) if (fb_vs[y][0] === 1'b0) cnt++;
    check("vsync_low_lines", cnt, VS);
    check("vsync_low_line40", fb_vs[40][0], 1'b0);

    // frame 1: shows bit 0
    pix_err = 0;
    disp_grid = one_bit;
    run_frame(0, top_bit);
    check("f1_pixels", pix_err, 0);
    check("bit0_first_px", fb_rgb[3][4], FILL);
    check("bit0_last_px", fb_rgb[4][5], FILL);
    check("bit0_right_nbr", fb_rgb[3][6], EMPTY);
    check("bit0_left_border", fb_rgb[3][3], BORDER);

    // frame 2: shows bit 255; grid_in changes mid-frame
    pix_err = 0;
    disp_grid = top_bit;
    run_frame(20, col0_pat);
    check("f2_pixels", pix_err, 0);
    check("bit255_first_px", fb_rgb[33][34], FILL);
    check("bit255_last_px", fb_rgb[34][35], FILL);
    check("bit255_right_border", fb_rgb[34][36], BORDER);
    check("outside_ring", fb_rgb[1][1], 12'h000);
    check("no_tear_old_kept", fb_rgb[33][4], EMPTY);

    // frame 3: new grid appears after the snapshot
    pix_err = 0;
    disp_grid = col0_pat;
    run_frame(0, {256{1'b1}});
    check("f3_pixels", pix_err, 0);
    check("new_grid_shown", fb_rgb[33][4], FILL);
    check("old_grid_gone", fb_rgb[34][35], EMPTY);

    // frame 4: all ones
    pix_err = 0;
    disp_grid = {256{1'b1}};
    run_frame(-1, 256'h0);
    check("f4_pixels", pix_err, 0);
    bad = 0;
    for (int y = YO; y < YO + 16 * CELL; y++)
      for (int x = XO; x < XO + 16 * CELL; x++)
        if (fb_rgb[y][x] !== FILL) bad++;
    check("all_ones_playfield", bad, 0);
    bad = 0;
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++)
        if ((x >= HV || y >= VV) && (fb_rgb[y][x] !== 12'h000 || fb_von[y][x] !== 1'b0)) bad++;
    check("blank_outside_visible", bad, 0);

    // frame tick spacing
    check("tick_count", tick_q.size(), 5);
    if (tick_q.size() >= 2) check("tick_period", tick_q[1] - tick_q[0], FRAME_CLK);
    bad = 0;
    for (int i = 1; i < tick_q.size(); i++) if (tick_q[i] - tick_q[i-1] != FRAME_CLK) bad++;
    check("tick_period_all", bad, 0);

    // mid-frame reset at (30,25)
    while (!(mh == 30 && mv == 25)) step();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_hsync", hsync, 1'b1);
    check("mid_rst_vsync", vsync, 1'b1);
    check("mid_rst_rgb", rgb, 12'h000);
    check("mid_rst_video_on", video_on, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_held_rgb", rgb, 12'h000);
    @(negedge clk);
    reset = 1'b0;
    set_prev_reset();
    mh = 0;
    mv = 0;
    pix_err = 0;
    disp_grid = 256'h0;
    steps = 0;
    while (steps < 200 && prev_hs !== 1'b0) begin
      step();
      steps++;
    end
    check("hsync_fall_after_rst", steps, HV + HF + 1);
    run_frame(-1, 256'h0);
    check("post_rst_pixels", pix_err, 0);

    check("hold_4clk", hold_err, 0);
    check("frame_tick_timing", tick_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
